data_mem_responder: RTL

// Memory-side responder for the core's load/store request interface (data_req/data_we/data_type/data_sign_ext).

---
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for the core load/store interface.
//                Word-organised data RAM, one outstanding request, response
//                (read data or write acknowledge) LATENCY cycles after grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int                  C_IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] C_MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]          C_LAT_M1    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pend_rdata_q, pend_rdata_d;
  logic                  pend_err_q, pend_err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [C_IDX_W-1:0]    w_idx;
  logic [1:0]            w_lane;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_be;
  logic                  w_err;
  logic                  w_gnt;
  logic                  w_wen;

  // Request decode: address split, legality checks, load extraction and store lane enables.
  always_comb begin
    w_idx   = data_addr_i[C_IDX_W+1:2];
    w_lane  = data_addr_i[1:0];
    w_word  = mem_q[w_idx];
    w_byte  = 8'(w_word >> {w_lane, 3'b000});
    w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_err   = 1'b0;
    w_load  = '0;
    w_be    = 4'b0000;
    w_wdata = '0;
    case (data_type_i)
      2'b00: begin
        w_load  = {{24{data_sign_ext_i & w_byte[7]}}, w_byte};
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{data_wdata_i[7:0]}};
      end
      2'b01: begin
        w_err   = data_addr_i[0];
        w_load  = {{16{data_sign_ext_i & w_half[15]}}, w_half};
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_wdata_i[15:0]}};
      end
      2'b10: begin
        w_err   = |w_lane;
        w_load  = w_word;
        w_be    = 4'b1111;
        w_wdata = data_wdata_i;
      end
      default: w_err = 1'b1;
    endcase
    if ({1'b0, data_addr_i} >= C_MEM_BYTES) begin
      w_err = 1'b1;
    end
    // Stores acknowledge with zero data; errors never return RAM contents.
    if (w_err || data_we_i) begin
      w_load = '0;
    end
  end

  assign w_gnt = data_req_i & ((state_q == ST_IDLE) | (state_q == ST_RESP));
  assign w_wen = w_gnt & data_we_i & ~w_err;

  // Data RAM: byte-lane write at the grant edge; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state logic: latency countdown, response capture at grant, publish at RESP entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          rdata_d = pend_rdata_q;
          err_d   = pend_err_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A grant from IDLE or RESP overrides the default transition (back-to-back).
    if (w_gnt) begin
      if (LATENCY == 1) begin
        state_d = ST_RESP;
        cnt_d   = 4'd0;
        rdata_d = w_load;
        err_d   = w_err;
      end else begin
        state_d      = ST_WAIT;
        cnt_d        = C_LAT_M1;
        pend_rdata_d = w_load;
        pend_err_d   = w_err;
      end
    end
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = (state_q == ST_RESP);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule
`default_nettype wire
